countdown_timer_bcd: RTL and testbench

- Downstream consumer of the 100 ms LFSR tick stage.
- Maintains a BCD countdown of seconds and tenths: 00.0 to 99.9.
- Drives the tick stage's enable, so the tick generator only runs while the countdown is active.
- Produces display digits and a one-cycle timeout pulse for the game control FSM.

---
 rtl/countdown_timer_bcd_pkg.sv | 20 ++
 rtl/countdown_timer_bcd_digit_dec.sv | 41 ++++
 rtl/countdown_timer_bcd.sv | 135 +++++++++++++
 tb/tb_countdown_timer_bcd.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types for the BCD countdown timer: FSM states, BCD digit type and clamp helper.
package countdown_timer_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Loaded digits above 9 are not valid BCD and saturate to 9.
    function automatic bcd_t clamp_bcd(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_dec.sv
// One BCD digit with load, decrement-enable and borrow-out; wraps 0 -> 9 on borrow.
module bcd_digit_dec
    import countdown_timer_bcd_pkg::*;
#(
    parameter bcd_t RESET_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    output logic [3:0] digit,
    output logic [3:0] nxt,
    output logic       borrow
);

    // nxt is exported so the parent can detect the terminal count before it is registered.
    always_comb begin
        nxt    = digit;
        borrow = 1'b0;
        if (ld) begin
            nxt = ld_val;
        end else if (dec) begin
            if (digit == 4'd0) begin
                nxt    = BCD_MAX;
                borrow = 1'b1;
            end else begin
                nxt = digit - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= RESET_VAL;
        end else begin
            digit <= nxt;
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// BCD countdown timer (00.0-99.9) driving the 100 ms tick stage enable.
// Optional blinking low-time warning is enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer_bcd
    import countdown_timer_bcd_pkg::*;
#(
    parameter int DEFAULT_TENS = 6,
    parameter int DEFAULT_ONES = 0,
    parameter int WARN_SEC     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms100,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic       tick_en,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic       running,
    output logic       timeout,
    output logic       warn
);

    state_t state, ctrl_state, next_state;
    logic   do_dec, do_ld, count_zero;
    bcd_t   ld_tens, ld_ones;
    bcd_t   tens_nxt, ones_nxt, tenths_nxt;
    logic   tenths_borrow, ones_borrow, tens_borrow;

    assign count_zero = (sec_tens == 4'd0) && (sec_ones == 4'd0) && (tenths == 4'd0);

    // Control decode in priority order abort > load > start > pause > tick.
    always_comb begin
        ctrl_state = state;
        do_dec     = 1'b0;
        do_ld      = 1'b0;
        ld_tens    = bcd_t'(DEFAULT_TENS);
        ld_ones    = bcd_t'(DEFAULT_ONES);
        if (abort) begin
            ctrl_state = IDLE;
            do_ld      = 1'b1;
        end else if (load && (state != RUN)) begin
            ctrl_state = IDLE;
            do_ld      = 1'b1;
            ld_tens    = clamp_bcd(load_tens);
            ld_ones    = clamp_bcd(load_ones);
        end else if (start && ((state == IDLE) || (state == PAUSE))) begin
            ctrl_state = count_zero ? DONE : RUN;
        end else if (pause && (state == RUN)) begin
            ctrl_state = PAUSE;
        end else if (ms100 && (state == RUN)) begin
            do_dec = 1'b1;
        end
    end

    // A decrement landing on 00.0 finishes the run; a tens borrow would be an underflow, so stop too.
    always_comb begin
        next_state = ctrl_state;
        if (do_dec && (tens_borrow ||
                       ((tens_nxt == 4'd0) && (ones_nxt == 4'd0) && (tenths_nxt == 4'd0)))) begin
            next_state = DONE;
        end
    end

    bcd_digit_dec #(.RESET_VAL(4'd0)) u_tenths (
        .clk    (clk),
        .rst    (rst),
        .ld     (do_ld),
        .ld_val (4'd0),
        .dec    (do_dec),
        .digit  (tenths),
        .nxt    (tenths_nxt),
        .borrow (tenths_borrow)
    );

    bcd_digit_dec #(.RESET_VAL(bcd_t'(DEFAULT_ONES))) u_ones (
        .clk    (clk),
        .rst    (rst),
        .ld     (do_ld),
        .ld_val (ld_ones),
        .dec    (tenths_borrow),
        .digit  (sec_ones),
        .nxt    (ones_nxt),
        .borrow (ones_borrow)
    );

    bcd_digit_dec #(.RESET_VAL(bcd_t'(DEFAULT_TENS))) u_tens (
        .clk    (clk),
        .rst    (rst),
        .ld     (do_ld),
        .ld_val (ld_tens),
        .dec    (ones_borrow),
        .digit  (sec_tens),
        .nxt    (tens_nxt),
        .borrow (tens_borrow)
    );

    // timeout fires on the single update that enters DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tick_en <= 1'b0;
            running <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= next_state;
            tick_en <= (next_state == RUN);
            running <= (next_state == RUN);
            timeout <= (next_state == DONE) && (state != DONE);
        end
    end

`ifdef COUNTDOWN_WARN_EN
    logic [6:0] next_secs;

    assign next_secs = 7'(tens_nxt) * 7'd10 + 7'(ones_nxt);

    // Blinks at 1 Hz: high for the upper half of each second while time is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warn <= 1'b0;
        end else begin
            warn <= ((next_state == RUN) || (next_state == PAUSE)) &&
                    (int'(next_secs) < WARN_SEC) && (tenths_nxt >= 4'd5);
        end
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd: directed plan plus randomized control traffic.
module tb_countdown_timer_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       ms100, load, start, pause, abort;
    logic [3:0] load_tens, load_ones;
    logic       tick_en, running, timeout, warn;
    logic [3:0] sec_tens, sec_ones, tenths;

    always #5 clk = ~clk;

    countdown_timer_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .ms100     (ms100),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .tick_en   (tick_en),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .tenths    (tenths),
        .running   (running),
        .timeout   (timeout),
        .warn      (warn)
    );

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic [3:0] tenths;
        logic       tick_en;
        logic       running;
        logic       timeout;
        logic       warn;
    } snap_t;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    m_state;
    int    m_cnt;

    // Reference model: remaining time held as an integer number of tenths.
    function automatic snap_t modelOutputs(input bit to);
        snap_t s;
        s.tens    = 4'(m_cnt / 100);
        s.ones    = 4'((m_cnt / 10) % 10);
        s.tenths  = 4'(m_cnt % 10);
        s.tick_en = (m_state == M_RUN);
        s.running = (m_state == M_RUN);
        s.timeout = to;
        s.warn    = 1'b0;
        return s;
    endfunction

    task automatic modelReset();
        m_state = M_IDLE;
        m_cnt   = 600;
    endtask

    task automatic modelStep(input bit a, input bit l, input int lt, input int lo,
                             input bit s, input bit p, input bit t, output snap_t e);
        int prev;
        prev = m_state;
        if (a) begin
            m_state = M_IDLE;
            m_cnt   = 600;
        end else if (l && m_state != M_RUN) begin
            m_cnt   = ((lt > 9) ? 9 : lt) * 100 + ((lo > 9) ? 9 : lo) * 10;
            m_state = M_IDLE;
        end else if (s && (m_state == M_IDLE || m_state == M_PAUSE)) begin
            m_state = (m_cnt == 0) ? M_DONE : M_RUN;
        end else if (p && m_state == M_RUN) begin
            m_state = M_PAUSE;
        end else if (t && m_state == M_RUN) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_state = M_DONE;
        end
        e = modelOutputs(m_state == M_DONE && prev != M_DONE);
    endtask

    task automatic checkField(input string tag, input string name,
                              input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s %s: got %h, expected %h at %0t", tag, name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input snap_t e, input string tag);
        checkField(tag, "digits", {sec_tens, sec_ones, tenths}, {e.tens, e.ones, e.tenths});
        checkField(tag, "tick_en", 12'(tick_en), 12'(e.tick_en));
        checkField(tag, "running", 12'(running), 12'(e.running));
        checkField(tag, "timeout", 12'(timeout), 12'(e.timeout));
        checkField(tag, "warn", 12'(warn), 12'(e.warn));
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
    task automatic applyStimulus(input bit a, input bit l, input logic [3:0] lt, input logic [3:0] lo,
                                 input bit s, input bit p, input bit t);
        snap_t e;
        @(negedge clk);
        abort = a; load = l; load_tens = lt; load_ones = lo;
        start = s; pause = p; ms100 = t;
        modelStep(a, l, int'(lt), int'(lo), s, p, t, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'd0, 4'd0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 4'd0, 4'd0, 0, 0, 1);
            applyStimulus(0, 0, 4'd0, 4'd0, 0, 0, 0);
        end
    endtask

    // dly > 0 asserts reset between clock edges to show it acts without a clock.
    task automatic applyReset(input int dly);
        @(negedge clk);
        abort = 0; load = 0; load_tens = 0; load_ones = 0;
        start = 0; pause = 0; ms100 = 0;
        #(dly);
        rst = 1'b0;
        exp_q.delete();
        modelReset();
        #1;
        checkOutput(modelOutputs(1'b0), "async_reset");
        repeat (2) @(negedge clk);
        checkOutput(modelOutputs(1'b0), "reset_hold");
        rst = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                snap_t e;
                e = exp_q.pop_front();
                checkOutput(e, "scoreboard");
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        logic [3:0] lt, lo;
        rst = 1'b0;
        abort = 0; load = 0; load_tens = 0; load_ones = 0;
        start = 0; pause = 0; ms100 = 0;
        modelReset();

        applyReset(0);

        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(3);
        idle(2);

        applyStimulus(0, 1, 4'd0, 4'd1, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(10);
        ticks(2);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        idle(2);

        applyStimulus(0, 1, 4'd1, 4'd3, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(6);
        applyStimulus(0, 0, 4'd0, 4'd0, 0, 1, 1);
        ticks(3);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(2);

        applyStimulus(0, 1, 4'hC, 4'hF, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(1);
        applyStimulus(0, 1, 4'd3, 4'd3, 0, 0, 0);
        idle(1);
        applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 1);
        applyStimulus(0, 1, 4'd2, 4'd0, 1, 0, 0);
        idle(1);

        applyStimulus(0, 1, 4'd0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        idle(3);
        applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(2);
        applyStimulus(1, 0, 4'd0, 4'd0, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            lt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            lo = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            applyStimulus(r < 2,
                          $urandom_range(0, 99) < 6, lt, lo,
                          $urandom_range(0, 99) < 12,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 55);
        end

        applyStimulus(0, 1, 4'd2, 4'd5, 0, 0, 0);
        applyStimulus(0, 0, 4'd0, 4'd0, 1, 0, 0);
        ticks(3);
        applyReset(2);
        idle(3);

        @(negedge clk);
        ms100 = 0; start = 0; load = 0; pause = 0; abort = 0;
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
